// File: rtl/replacement_ctrl.sv
// Replacement sequencer between cache front-end, replacement policy and refill engine:
// hit policy updates, miss victim selection with refill handshake, saturating statistics.
module replacement_ctrl #(
  parameter int N_WAYS     = 8,
  parameter int LINE_OFF_W = 4,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LINE_OFF_W-1:0] req_line_addr,
  input  logic [N_WAYS-1:0]     req_way_hit,
  input  logic [N_WAYS-1:0]     req_line_valid,
  output logic                  req_done,
  output logic [N_WAYS-1:0]     victim_way,
  output logic                  rp_write_en,
  output logic [LINE_OFF_W-1:0] rp_line_addr,
  output logic [N_WAYS-1:0]     rp_way_hit,
  input  logic [N_WAYS-1:0]     rp_way_select,
  output logic                  refill_req,
  input  logic                  refill_ack,
  input  logic                  refill_done,
  output logic [NWAY_W-1:0]     refill_way_bin,
  output logic [LINE_OFF_W-1:0] refill_line_addr,
  input  logic                  stat_clear,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    VICTIM      = 3'd1,
    REFILL_REQ  = 3'd2,
    REFILL_WAIT = 3'd3,
    UPDATE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_s;
  logic [LINE_OFF_W-1:0] addr_r;
  logic [N_WAYS-1:0]     valid_r;
  logic [N_WAYS-1:0]     victim_r;
  logic                  done_r;
  logic [CNT_W-1:0]      hit_cnt_r;
  logic [CNT_W-1:0]      miss_cnt_r;

  logic                  hit_acc_s;
  logic                  miss_acc_s;
  logic                  req_ready_s;
  logic                  rp_write_en_s;
  logic                  refill_req_s;
  logic [LINE_OFF_W-1:0] rp_line_addr_s;
  logic [N_WAYS-1:0]     rp_way_hit_s;
  logic [N_WAYS-1:0]     victim_sel_s;

  // Lowest-index way whose valid bit is clear; zero when every way is valid.
  function automatic logic [N_WAYS-1:0] first_invalid(input logic [N_WAYS-1:0] valid);
    logic [N_WAYS-1:0] sel;
    sel = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [NWAY_W-1:0] onehot_to_bin(input logic [N_WAYS-1:0] oh);
    logic [NWAY_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (oh[i]) begin
        bin = bin | NWAY_W'(i);
      end
    end
    return bin;
  endfunction

  // Request classification and victim choice; a multi-hot hit vector still counts as a hit.
  always_comb begin
    hit_acc_s    = 1'b0;
    miss_acc_s   = 1'b0;
    victim_sel_s = '0;
    if (state_r == IDLE && req_valid) begin
      hit_acc_s  = |req_way_hit;
      miss_acc_s = ~|req_way_hit;
    end else begin
      hit_acc_s  = 1'b0;
      miss_acc_s = 1'b0;
    end
    if (&valid_r) begin
      victim_sel_s = rp_way_select;
    end else begin
      victim_sel_s = first_invalid(valid_r);
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_s        = state_r;
    req_ready_s    = 1'b0;
    rp_write_en_s  = 1'b0;
    rp_way_hit_s   = '0;
    refill_req_s   = 1'b0;
    rp_line_addr_s = addr_r;
    case (state_r)
      IDLE: begin
        req_ready_s    = 1'b1;
        rp_line_addr_s = req_line_addr;
        if (hit_acc_s) begin
          rp_write_en_s = 1'b1;
          rp_way_hit_s  = req_way_hit;
          state_s       = IDLE;
        end else if (miss_acc_s) begin
          state_s = VICTIM;
        end else begin
          state_s = IDLE;
        end
      end
      VICTIM: begin
        state_s = REFILL_REQ;
      end
      REFILL_REQ: begin
        refill_req_s = 1'b1;
        // A done without an ack implies the ack as well.
        if (refill_done) begin
          state_s = UPDATE;
        end else if (refill_ack) begin
          state_s = REFILL_WAIT;
        end else begin
          state_s = REFILL_REQ;
        end
      end
      REFILL_WAIT: begin
        if (refill_done) begin
          state_s = UPDATE;
        end else begin
          state_s = REFILL_WAIT;
        end
      end
      UPDATE: begin
        rp_write_en_s = 1'b1;
        rp_way_hit_s  = victim_r;
        state_s       = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched miss context, victim register and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      valid_r  <= '0;
      victim_r <= '0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= hit_acc_s | (state_r == UPDATE);
      if (miss_acc_s) begin
        addr_r  <= req_line_addr;
        valid_r <= req_line_valid;
      end
      // Victim held from REFILL_REQ through UPDATE, cleared on return to IDLE.
      if (state_r == VICTIM) begin
        victim_r <= victim_sel_s;
      end else if (state_r == UPDATE) begin
        victim_r <= '0;
      end
    end
  end

  // Saturating statistics; reset beats clear, clear beats increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else if (stat_clear) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (hit_acc_s && hit_cnt_r != CNT_MAX) begin
        hit_cnt_r <= hit_cnt_r + CNT_ONE;
      end
      if (miss_acc_s && miss_cnt_r != CNT_MAX) begin
        miss_cnt_r <= miss_cnt_r + CNT_ONE;
      end
    end
  end

  assign req_ready        = req_ready_s;
  assign req_done         = done_r;
  assign victim_way       = victim_r;
  assign rp_write_en      = rp_write_en_s;
  assign rp_line_addr     = rp_line_addr_s;
  assign rp_way_hit       = rp_way_hit_s;
  assign refill_req       = refill_req_s;
  assign refill_way_bin   = onehot_to_bin(victim_r);
  assign refill_line_addr = addr_r;
  assign hit_cnt          = hit_cnt_r;
  assign miss_cnt         = miss_cnt_r;

endmodule

// File: tb/tb_replacement_ctrl.sv
// Scoreboard bench for replacement_ctrl: stimulus pushes expected policy writes and
// completion cycles, a negedge monitor pops and compares them.
module tb_replacement_ctrl;

  localparam int NW = 4;
  localparam int AW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_valid, req_ready, req_done, rp_write_en, refill_req;
  logic          refill_ack, refill_done, stat_clear;
  logic [AW-1:0] req_line_addr, rp_line_addr, refill_line_addr;
  logic [NW-1:0] req_way_hit, req_line_valid, victim_way, rp_way_hit, rp_way_select;
  logic [1:0]    refill_way_bin;
  logic [CW-1:0] hit_cnt, miss_cnt;

  // Small-counter instance for saturation
  logic          s_req_valid, s_req_ready, s_req_done, s_rp_write_en, s_refill_req, s_stat_clear;
  logic [AW-1:0] s_rp_line_addr, s_refill_line_addr;
  logic [NW-1:0] s_req_way_hit, s_victim_way, s_rp_way_hit;
  logic [1:0]    s_refill_way_bin;
  logic [1:0]    s_hit_cnt, s_miss_cnt;

  replacement_ctrl #(.N_WAYS(NW), .LINE_OFF_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_line_addr(req_line_addr), .req_way_hit(req_way_hit), .req_line_valid(req_line_valid),
    .req_done(req_done), .victim_way(victim_way), .rp_write_en(rp_write_en),
    .rp_line_addr(rp_line_addr), .rp_way_hit(rp_way_hit), .rp_way_select(rp_way_select),
    .refill_req(refill_req), .refill_ack(refill_ack), .refill_done(refill_done),
    .refill_way_bin(refill_way_bin), .refill_line_addr(refill_line_addr),
    .stat_clear(stat_clear), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  replacement_ctrl #(.N_WAYS(NW), .LINE_OFF_W(AW), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_line_addr(4'd1), .req_way_hit(s_req_way_hit), .req_line_valid(4'b1111),
    .req_done(s_req_done), .victim_way(s_victim_way), .rp_write_en(s_rp_write_en),
    .rp_line_addr(s_rp_line_addr), .rp_way_hit(s_rp_way_hit), .rp_way_select(4'b0001),
    .refill_req(s_refill_req), .refill_ack(1'b0), .refill_done(1'b0),
    .refill_way_bin(s_refill_way_bin), .refill_line_addr(s_refill_line_addr),
    .stat_clear(s_stat_clear), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  typedef struct {
    int            cyc;
    logic [NW-1:0] way;
    logic [AW-1:0] addr;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  wr_t mon_e;
  int  mon_d;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  exp_hit = 0;
  int  exp_miss = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every policy write and completion pulse must match a queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (rp_write_en === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_rp_write", 32'(rp_way_hit), 32'd0);
          chk("unexpected_rp_write_en", 32'(rp_write_en), 32'd0);
        end else begin
          mon_e = wr_q.pop_front();
          chk("rp_write_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rp_way_hit", 32'(rp_way_hit), 32'(mon_e.way));
          chk("rp_line_addr", 32'(rp_line_addr), 32'(mon_e.addr));
        end
      end
      if (req_done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_req_done", 32'(req_done), 32'd0);
        end else begin
          mon_d = done_q.pop_front();
          chk("req_done_cycle", 32'(cyc), 32'(mon_d));
        end
      end
    end
  end

  task automatic hit(input logic [AW-1:0] addr, input logic [NW-1:0] way);
    req_valid     = 1'b1;
    req_way_hit   = way;
    req_line_addr = addr;
    chk("hit_req_ready", 32'(req_ready), 32'd1);
    wr_q.push_back('{cyc, way, addr});
    done_q.push_back(cyc + 1);
    exp_hit++;
    tick();
  endtask

  // mode 0: ack then done after wait_n cycles; 1: ack and done together; 2: done alone
  task automatic miss(input logic [AW-1:0] addr, input logic [NW-1:0] valid,
                      input logic [NW-1:0] sel, input logic [NW-1:0] exp_way,
                      input int wait_n, input int mode);
    rp_way_select  = sel;
    req_valid      = 1'b1;
    req_way_hit    = 4'b0000;
    req_line_addr  = addr;
    req_line_valid = valid;
    chk("miss_no_write", 32'(rp_write_en), 32'd0);
    exp_miss++;
    tick();
    req_valid      = 1'b0;
    req_line_addr  = ~addr;
    req_line_valid = 4'b0000;
    chk("victim_rp_addr", 32'(rp_line_addr), 32'(addr));
    chk("victim_ready", 32'(req_ready), 32'd0);
    chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    tick();
    chk("refill_req", 32'(refill_req), 32'd1);
    chk("refill_way_bin", 32'(refill_way_bin), 32'($clog2(exp_way)));
    chk("victim_way_req", 32'(victim_way), 32'(exp_way));
    chk("refill_line_addr", 32'(refill_line_addr), 32'(addr));
    if (mode == 0) begin
      refill_ack = 1'b1;
      tick();
      refill_ack = 1'b0;
      chk("refill_req_wait", 32'(refill_req), 32'd0);
      for (int k = 1; k < wait_n; k++) begin
        chk("victim_way_wait", 32'(victim_way), 32'(exp_way));
        tick();
      end
    end
    refill_ack  = (mode == 1);
    refill_done = 1'b1;
    wr_q.push_back('{cyc + 1, exp_way, addr});
    done_q.push_back(cyc + 2);
    tick();
    refill_ack  = 1'b0;
    refill_done = 1'b0;
    chk("victim_way_update", 32'(victim_way), 32'(exp_way));
    chk("refill_req_update", 32'(refill_req), 32'd0);
    tick();
    chk("victim_way_idle", 32'(victim_way), 32'd0);
    chk("ready_after_miss", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_line_addr = '0; req_way_hit = '0; req_line_valid = 4'b1111;
    rp_way_select = 4'b0001; refill_ack = 1'b0; refill_done = 1'b0; stat_clear = 1'b0;
    s_req_valid = 1'b0; s_req_way_hit = 4'b0001; s_stat_clear = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_refill_req", 32'(refill_req), 32'd0);
    chk("rst_victim_way", 32'(victim_way), 32'd0);
    chk("rst_rp_write_en", 32'(rp_write_en), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single hit
    hit(4'd3, 4'b0010);
    req_valid = 1'b0;
    chk("hit_cnt_1", 32'(hit_cnt), 32'(exp_hit));
    tick();

    // Miss: invalid way wins over policy choice, late refill_done
    miss(4'd5, 4'b1011, 4'b0001, 4'b0100, 4, 0);
    // Miss with all ways valid: policy victim, ack and done together
    miss(4'd9, 4'b1111, 4'b1000, 4'b1000, 0, 1);
    // done without ack
    miss(4'd2, 4'b1110, 4'b1000, 4'b0001, 0, 2);
    chk("miss_cnt_3", 32'(miss_cnt), 32'd3);

    // Ten back-to-back hits after a statistics clear
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    chk("clr_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("clr_miss_cnt", 32'(miss_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      hit(4'(i), 4'(1 << (i % 4)));
    end
    req_valid = 1'b0;
    chk("hit_cnt_10", 32'(hit_cnt), 32'd10);
    tick();

    // Reset while waiting for refill data
    rp_way_select  = 4'b0001;
    req_valid      = 1'b1;
    req_way_hit    = 4'b0000;
    req_line_addr  = 4'd7;
    req_line_valid = 4'b0000;
    tick();
    req_valid = 1'b0;
    tick();
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    chk("pre_rst_refill_req", 32'(refill_req), 32'd0);
    chk("pre_rst_victim", 32'(victim_way), 32'b0001);
    reset = 1'b1;
    tick();
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_refill_req", 32'(refill_req), 32'd0);
    chk("abort_victim_way", 32'(victim_way), 32'd0);
    chk("abort_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("abort_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("abort_rp_write_en", 32'(rp_write_en), 32'd0);
    chk("abort_s_hit_cnt", 32'(s_hit_cnt), 32'd0);
    reset = 1'b0;
    refill_done = 1'b1;
    tick();
    refill_done = 1'b0;
    tick();
    tick();

    // Two-bit counter saturation and clear priority
    s_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_hit_cnt", 32'(s_hit_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    s_stat_clear = 1'b1;
    tick();
    chk("clear_beats_hit", 32'(s_hit_cnt), 32'd0);
    s_stat_clear = 1'b0;
    tick();
    chk("hit_after_clear", 32'(s_hit_cnt), 32'd1);
    s_req_valid = 1'b0;

    tick();
    tick();
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/replacement_ctrl.md
Name: replacement_ctrl

Overview:
Sequencer between the cache front-end, the replacement-policy block and the line-refill engine.
- On a hit, issues a single-cycle policy update.
- On a miss, picks the victim way (an invalid way first, otherwise the policy victim), holds it stable through the refill handshake, then writes the refilled way back to the policy as most-recently-used.
- Keeps saturating hit/miss counters for performance monitoring.

Parameters:
- N_WAYS, 8, number of ways (power of 2, >=2).
- LINE_OFF_W, 4, line-index width.
- NWAY_W, $clog2(N_WAYS), way-index width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  lookup request from front-end.
- req_ready  out  1  controller can accept a request.
- req_line_addr  in  LINE_OFF_W  line index of request.
- req_way_hit  in  N_WAYS  one-hot tag-match result; all-zero means miss.
- req_line_valid  in  N_WAYS  valid bits of the addressed set.
- req_done  out  1  one-cycle pulse when the request has fully completed.
- victim_way  out  N_WAYS  one-hot victim, stable from REFILL_REQ until UPDATE.
- rp_write_en  out  1  policy-memory write enable.
- rp_line_addr  out  LINE_OFF_W  policy-memory address.
- rp_way_hit  out  N_WAYS  one-hot way reported to the policy.
- rp_way_select  in  N_WAYS  policy victim, combinational from rp_line_addr.
- refill_req  out  1  refill request to the back-end.
- refill_ack  in  1  back-end accepted the refill.
- refill_done  in  1  refill data has been written.
- refill_way_bin  out  NWAY_W  binary index of the victim.
- refill_line_addr  out  LINE_OFF_W  line being refilled.
- stat_clear  in  1  synchronous clear of both counters.
- hit_cnt  out  CNT_W  hits counted.
- miss_cnt  out  CNT_W  misses counted.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; all outputs 0 except req_ready=1; latched addr/valid/victim=0; counters=0.
- Reset in any state aborts the operation: refill_req drops the next edge and no policy write is issued.
- States: IDLE, VICTIM, REFILL_REQ, REFILL_WAIT, UPDATE.
- req_ready=1 only in IDLE. A request is accepted when req_valid&req_ready.
- rp_line_addr = req_line_addr in IDLE, otherwise the latched address.
- IDLE, hit accepted (|req_way_hit):
  - Same cycle: rp_write_en=1, rp_way_hit=req_way_hit.
  - Next cycle: req_done=1 and hit_cnt++.
  - State stays IDLE, so back-to-back hits run at 1/cycle.
- IDLE, miss accepted:
  - Latch line_addr and line_valid; miss_cnt++ next cycle.
  - Next state VICTIM. rp_write_en=0.
- VICTIM (1 cycle):
  - If any latched valid bit is 0, victim = lowest-index invalid way.
  - Otherwise victim = rp_way_select (read at the latched address).
  - Victim is registered. Next state REFILL_REQ.
- REFILL_REQ:
  - refill_req=1; refill_way_bin and refill_line_addr are driven from the latched values.
  - refill_ack -> REFILL_WAIT.
  - refill_ack & refill_done in the same cycle -> UPDATE directly.
  - refill_done without refill_ack is treated as both.
- REFILL_WAIT: refill_req=0. refill_done -> UPDATE. Waits indefinitely; there is no timeout.
- UPDATE (1 cycle):
  - rp_write_en=1, rp_way_hit=victim_way.
  - Next state IDLE; req_done pulses in the following cycle.
- Miss latency: accept at T; refill_req visible at T+2; done sampled at X -> UPDATE X+1, req_done X+2.
- A req_way_hit with more than one bit set is illegal; behaviour is undefined, but it is still classified as a hit.
- Counters saturate at 2^CNT_W-1.
  - stat_clear has priority over an increment in the same cycle.
  - Reset overrides stat_clear.
- victim_way is 0 in IDLE.

Test Plan:
1. N_WAYS=4, hit req_way_hit=0010 at addr 3 -> rp_write_en=1, rp_way_hit=0010, rp_line_addr=3 same cycle; req_done next cycle; hit_cnt=1.
2. Miss at addr 5, req_line_valid=1011, refill_ack immediate, refill_done 4 cycles later -> refill_way_bin=2, victim_way=0100 stable throughout; UPDATE writes 0100 to addr 5; miss_cnt=1.
3. Miss with req_line_valid=1111 and rp_way_select=1000 -> refill_way_bin=3; refill_ack and refill_done in the same cycle go straight to UPDATE.
4. Ten back-to-back hits with req_valid held high -> req_ready stays 1; ten req_done pulses on consecutive cycles; hit_cnt=10.
5. reset asserted during REFILL_WAIT -> next cycle state IDLE, refill_req=0, req_ready=1, counters 0, no rp_write_en.
6. CNT_W=2: five hits -> hit_cnt saturates at 3. stat_clear coinciding with a hit -> hit_cnt=0.
